// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, ACC, B, ALU and OUT on one shared W bus, plus a program-load port.
// Latency: the bus, the ALU and the RAM read are combinational. Register loads are visible one cycle after the enabling edge.
// Backpressure: none. low_halt=0 freezes the datapath state. prog_mode=1 freezes the registers and disables every bus driver.
// Ports: clk, low_clr (async clear); control word (inc, *_out_en, low_ld_*, sub_add, low_halt);
//        prog_mode/prog_we/prog_addr/prog_data (RAM fill); op_code, out_data, w_bus, carry, bus_err, halted.
module sap1_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              low_clr,
  input  logic              inc,
  input  logic              pc_out_en,
  input  logic              low_ld_mar,
  input  logic              low_mem_out_en,
  input  logic              low_ld_ir,
  input  logic              low_ir_out_en,
  input  logic              low_ld_acc,
  input  logic              acc_out_en,
  input  logic              sub_add,
  input  logic              subadd_out_en,
  input  logic              low_ld_b_reg,
  input  logic              low_ld_out_reg,
  input  logic              low_halt,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        op_code,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] w_bus,
  output logic              carry,
  output logic              bus_err,
  output logic              halted
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] out_reg;
  logic [DATA_W-1:0] ram [DEPTH];

  // Registers advance only when running: not halted and not loading a program.
  logic run_en;
  assign run_en = low_halt & ~prog_mode;

  // Effective bus drivers; program mode removes all of them from the bus.
  logic pc_drv, mem_drv, ir_drv, acc_drv, alu_drv;
  assign pc_drv  = pc_out_en       & ~prog_mode;
  assign mem_drv = ~low_mem_out_en & ~prog_mode;
  assign ir_drv  = ~low_ir_out_en  & ~prog_mode;
  assign acc_drv = acc_out_en      & ~prog_mode;
  assign alu_drv = subadd_out_en   & ~prog_mode;

  logic [4:0] drv_vec;
  logic       multi_drv;
  assign drv_vec   = {pc_drv, mem_drv, ir_drv, acc_drv, alu_drv};
  // Clearing the lowest set bit leaves something only if two or more drivers are on.
  assign multi_drv = |(drv_vec & (drv_vec - 5'd1));

  // Subtraction is ACC + ~B + 1, so bit DATA_W is the no-borrow flag (ACC >= B).
  logic [DATA_W-1:0] b_opnd;
  logic [DATA_W:0]   alu_sum;
  assign b_opnd  = sub_add ? ~b_reg : b_reg;
  assign alu_sum = {1'b0, acc} + {1'b0, b_opnd} + {{DATA_W{1'b0}}, sub_add};

  // Fixed-priority bus: PC > RAM > IR > ACC > ALU. An idle bus reads 0.
  always_comb begin
    w_bus = '0;
    if (pc_drv)       w_bus = DATA_W'(pc);
    else if (mem_drv) w_bus = ram[mar];
    else if (ir_drv)  w_bus = DATA_W'(ir[3:0]);
    else if (acc_drv) w_bus = acc;
    else if (alu_drv) w_bus = alu_sum[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge low_clr) begin
    if (!low_clr) begin
      pc      <= '0;
      mar     <= '0;
      ir      <= '0;
      acc     <= '0;
      b_reg   <= '0;
      out_reg <= '0;
      carry   <= 1'b0;
      bus_err <= 1'b0;
      halted  <= 1'b0;
    end else begin
      halted  <= ~low_halt;
      // Contention is still sampled while halted; it is sticky until clear.
      bus_err <= bus_err | multi_drv;
      if (run_en) begin
        if (inc)            pc      <= pc + 1'b1;
        if (!low_ld_mar)    mar     <= w_bus[ADDR_W-1:0];
        if (!low_ld_ir)     ir      <= w_bus;
        if (!low_ld_acc)    acc     <= w_bus;
        if (!low_ld_b_reg)  b_reg   <= w_bus;
        if (!low_ld_out_reg) out_reg <= w_bus;
        if (subadd_out_en)  carry   <= alu_sum[DATA_W];
      end
    end
  end

  // The RAM is not cleared by reset. A write that coincides with an active clear is dropped.
  always_ff @(posedge clk) begin
    if (low_clr && prog_mode && prog_we) ram[prog_addr] <= prog_data;
  end

  assign op_code  = ir[DATA_W-1 -: 4];
  assign out_data = out_reg;

endmodule
